// File: rtl/mips_dmem_pkg.sv
// rtl/mips_dmem_pkg.sv - MMIO offsets, STATUS layout and address decode for the MIPS data-memory responder
package mips_dmem_pkg;

  localparam logic [15:0] OFF_CYCLE  = 16'h0000;
  localparam logic [15:0] OFF_TXDATA = 16'h0004;
  localparam logic [15:0] OFF_STATUS = 16'h0008;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_MISALIGN  = 3;
  localparam int ST_COUNT_LSB = 8;
  localparam int ST_COUNT_W   = 8;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_CYCLE,
    SEL_TXDATA,
    SEL_STATUS,
    SEL_NONE
  } sel_t;

  function automatic sel_t decode(input logic [31:0] addr, input logic [15:0] base_hi);
    if (addr[31:16] != base_hi) return SEL_RAM;
    case (addr[15:0])
      OFF_CYCLE:  return SEL_CYCLE;
      OFF_TXDATA: return SEL_TXDATA;
      OFF_STATUS: return SEL_STATUS;
      default:    return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mips_dmem_if.sv
// rtl/mips_dmem_if.sv - core data port plus output-FIFO stream between core side and the data memory
interface mips_dmem_if;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;

  modport master (
    output memwrite, aluout, writedata, out_ready,
    input  readdata, out_valid, out_data
  );

  modport slave (
    input  memwrite, aluout, writedata, out_ready,
    output readdata, out_valid, out_data
  );
endinterface

// File: rtl/mips_dmem_fifo.sv
// rtl/mips_dmem_fifo.sv - output FIFO with registered head word/valid and a drop strobe on overflow
module mips_dmem_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          ready,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          drop
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_next;
  logic [CW-1:0] count_next;
  logic [W-1:0]  head_next;
  logic          pop, push_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop     = out_valid & ready;
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  assign count_next = count + CW'(push_ok) - CW'(pop);
  assign rd_next    = rd_ptr + PW'(pop);

  // The head after this edge is the pushed word only when nothing older survives the pop.
  always_comb begin
    head_next = '0;
    if (count_next == '0)
      head_next = '0;
    else if ((count - CW'(pop)) == '0)
      head_next = din;
    else
      head_next = mem[rd_next];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      rd_ptr    <= rd_next;
      wr_ptr    <= wr_ptr + PW'(push_ok);
      count     <= count_next;
      out_valid <= (count_next != '0);
      out_data  <= head_next;
    end
  end

endmodule

// File: rtl/mips_dmem.sv
// rtl/mips_dmem.sv - data RAM + MMIO (cycle counter, TX FIFO, STATUS); MIPS_DMEM_ALIGN_CHECK_EN adds misalign tracking
module mips_dmem
  import mips_dmem_pkg::*;
#(
  parameter int          ADDR_BITS  = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  mips_dmem_if.slave   bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]          ram [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] widx;
  sel_t                 sel;
  logic                 cyc_we, tx_push, st_we;
  logic [31:0]          cycle;
  logic [31:0]          status;
  logic                 overflow, misalign;
  logic                 fifo_full, fifo_empty, fifo_drop;
  logic [CW-1:0]        fifo_count;

  assign widx    = bus.aluout[ADDR_BITS+1:2];
  assign sel     = decode(bus.aluout, MMIO_BASE[31:16]);
  assign cyc_we  = bus.memwrite & (sel == SEL_CYCLE);
  assign tx_push = bus.memwrite & (sel == SEL_TXDATA);
  assign st_we   = bus.memwrite & (sel == SEL_STATUS);

  always_ff @(posedge clk) begin
    if (bus.memwrite && sel == SEL_RAM) ram[widx] <= bus.writedata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      cycle <= '0;
    else if (cyc_we) cycle <= bus.writedata;
    else             cycle <= cycle + 32'd1;
  end

  // A drop in the same cycle as a clear leaves the flag set so no overflow goes unseen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              overflow <= 1'b0;
    else if (fifo_drop)                      overflow <= 1'b1;
    else if (st_we && bus.writedata[ST_OVF]) overflow <= 1'b0;
  end

`ifdef MIPS_DMEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                   misalign <= 1'b0;
    else if (bus.aluout[1:0] != 2'b00)            misalign <= 1'b1;
    else if (st_we && bus.writedata[ST_MISALIGN]) misalign <= 1'b0;
  end
`else
  assign misalign = 1'b0;
`endif

  mips_dmem_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .din       (bus.writedata),
    .ready     (bus.out_ready),
    .out_valid (bus.out_valid),
    .out_data  (bus.out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .drop      (fifo_drop)
  );

  always_comb begin
    status = '0;
    status[ST_EMPTY]    = fifo_empty;
    status[ST_FULL]     = fifo_full;
    status[ST_OVF]      = overflow;
    status[ST_MISALIGN] = misalign;
    status[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(fifo_count);
  end

  always_comb begin
    bus.readdata = '0;
    if (reset) begin
      case (sel)
        SEL_RAM:    bus.readdata = ram[widx];
        SEL_CYCLE:  bus.readdata = cycle;
        SEL_STATUS: bus.readdata = status;
        default:    bus.readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_dmem.sv
// tb/tb_mips_dmem.sv - randomized and directed checks of mips_dmem against a queue/array reference model
module tb_mips_dmem;

  localparam logic [31:0] A_CYC = 32'hFFFF_0000;
  localparam logic [31:0] A_TX  = 32'hFFFF_0004;
  localparam logic [31:0] A_ST  = 32'hFFFF_0008;
  localparam int          DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_dmem_if bus();

  mips_dmem dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] ram_m [256];
  bit          ram_known [256];
  logic [31:0] q [$];
  logic [31:0] cyc_m;
  bit          ovf_m, mis_m;

  logic [31:0] last_rd, last_od;
  logic        last_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] status_m();
    return {16'h0, 8'(q.size()), 4'h0, mis_m, ovf_m, q.size() == DEPTH, q.size() == 0};
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    return a[31:16] == 16'hFFFF;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (is_mmio(a)) begin
      if (a[15:0] == 16'h0) return cyc_m;
      if (a[15:0] == 16'h8) return status_m();
      return 32'h0;
    end
    return ram_m[(a >> 2) % 256];
  endfunction

  task automatic edge_update(input bit we, input logic [31:0] a, input logic [31:0] wd, input bit rdy);
    bit pop;
    pop = (q.size() != 0) && rdy;
    if (pop) void'(q.pop_front());
    if (we && is_mmio(a) && a[15:0] == 16'h4) begin
      if (q.size() < DEPTH) q.push_back(wd);
      else ovf_m = 1;
    end
    if (we && is_mmio(a) && a[15:0] == 16'h8) begin
      if (wd[2]) ovf_m = 0;
`ifdef MIPS_DMEM_ALIGN_CHECK_EN
      if (wd[3]) mis_m = 0;
`endif
    end
`ifdef MIPS_DMEM_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) mis_m = 1;
`endif
    if (we && is_mmio(a) && a[15:0] == 16'h0) cyc_m = wd;
    else cyc_m = cyc_m + 32'd1;
    if (we && !is_mmio(a)) begin
      ram_m[(a >> 2) % 256]     = wd;
      ram_known[(a >> 2) % 256] = 1;
    end
  endtask

  task automatic step(input bit we, input logic [31:0] a, input logic [31:0] wd, input bit rdy);
    #1;
    bus.memwrite  = we;
    bus.aluout    = a;
    bus.writedata = wd;
    bus.out_ready = rdy;
    @(negedge clk);
    last_rd    = bus.readdata;
    last_valid = bus.out_valid;
    last_od    = bus.out_data;
    if (is_mmio(a) || ram_known[(a >> 2) % 256])
      check("readdata", bus.readdata, model_read(a));
    check("out_valid", {31'h0, bus.out_valid}, {31'h0, q.size() != 0});
    if (q.size() != 0) check("out_data", bus.out_data, q[0]);
    @(posedge clk);
    edge_update(we, a, wd, rdy);
  endtask

  task automatic do_reset();
    #2;
    reset         = 1'b0;
    bus.memwrite  = 1'b0;
    bus.aluout    = A_ST;
    bus.writedata = 32'h0;
    #1;
    check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("rst_out_data", bus.out_data, 32'h0);
    check("rst_readdata", bus.readdata, 32'h0);
    q.delete();
    cyc_m = 0;
    ovf_m = 0;
    mis_m = 0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    edge_update(0, A_ST, 32'h0, bus.out_ready);
  endtask

  initial begin
    reset         = 1'b0;
    bus.memwrite  = 1'b0;
    bus.aluout    = A_ST;
    bus.writedata = 32'h0;
    bus.out_ready = 1'b0;
    cyc_m = 0;
    ovf_m = 0;
    mis_m = 0;
    for (int i = 0; i < 256; i++) ram_known[i] = 0;

    do_reset();

    for (int i = 0; i < 9; i++) step(0, A_ST, 32'h0, 0);
    step(0, A_CYC, 32'h0, 0);
    check("cycle_after_idle", last_rd, 32'd10);
    step(1, A_CYC, 32'hFFFF_FFFE, 0);
    step(0, A_CYC, 32'h0, 0);
    check("cycle_load", last_rd, 32'hFFFF_FFFE);
    step(0, A_CYC, 32'h0, 0);
    check("cycle_inc", last_rd, 32'hFFFF_FFFF);
    step(0, A_CYC, 32'h0, 0);
    check("cycle_wrap", last_rd, 32'h0);

    for (int i = 0; i < 256; i++) step(1, 32'(i * 4), $urandom, 0);

    step(1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
    step(0, 32'h0000_0010, 32'h0, 0);
    check("ram_load", last_rd, 32'hDEAD_BEEF);
    step(0, 32'h0000_0410, 32'h0, 0);
    check("ram_alias", last_rd, 32'hDEAD_BEEF);

    for (int i = 1; i <= 5; i++) step(1, A_TX, 32'(i), 0);
    step(0, A_ST, 32'h0, 0);
    check("status_full_ovf", last_rd, 32'h0000_0406);
    for (int i = 1; i <= 4; i++) begin
      step(0, A_ST, 32'h0, 1);
      check("drain_valid", {31'h0, last_valid}, 32'h1);
      check("drain_data", last_od, 32'(i));
    end
    step(0, A_ST, 32'h0, 0);
    check("drain_empty", {31'h0, last_valid}, 32'h0);
    step(1, A_ST, 32'h4, 0);
    step(0, A_ST, 32'h0, 0);
    check("status_cleared", last_rd, 32'h0000_0001);

    for (int i = 1; i <= 4; i++) step(1, A_TX, 32'(i), 0);
    step(0, A_ST, 32'h0, 0);
    check("status_full", last_rd, 32'h0000_0402);
    step(1, A_TX, 32'h9, 1);
    step(0, A_ST, 32'h0, 0);
    check("full_push_pop", last_rd, 32'h0000_0402);
    step(1, A_TX, 32'h7, 0);
    step(0, A_ST, 32'h0, 0);
    check("ovf_set", last_rd, 32'h0000_0406);
    step(1, A_ST, 32'h4, 0);
    step(0, A_ST, 32'h0, 0);
    check("ovf_w1c", last_rd, 32'h0000_0402);
    for (int i = 0; i < 5; i++) step(0, A_ST, 32'h0, 1);

    step(1, 32'h0000_0020, 32'h1234_5678, 0);
    step(1, A_TX, 32'hA5, 0);
    step(0, A_ST, 32'h0, 0);
    do_reset();
    step(0, A_ST, 32'h0, 0);
    check("status_after_reset", last_rd, 32'h0000_0001);
    step(0, 32'h0000_0020, 32'h0, 0);
    check("ram_survives_reset", last_rd, 32'h1234_5678);

    step(1, 32'h0000_0013, 32'hCAFE_F00D, 0);
    step(0, A_ST, 32'h0, 0);
`ifdef MIPS_DMEM_ALIGN_CHECK_EN
    check("misalign_set", last_rd, 32'h0000_0009);
`else
    check("misalign_absent", last_rd, 32'h0000_0001);
`endif
    step(1, A_ST, 32'h8, 0);
    step(0, A_ST, 32'h0, 0);
    check("misalign_clear", last_rd, 32'h0000_0001);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] ra;
      bit          rdy;
      ra  = {16'($urandom_range(0, 16'hFFFE)), 16'($urandom) & 16'hFFFC};
      rdy = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 7))
        0:       step(1, ra, $urandom, rdy);
        1:       step(0, ra, 32'h0, rdy);
        2, 3:    step(1, A_TX, $urandom, rdy);
        4:       step(0, A_ST, 32'h0, rdy);
        5:       step(0, A_CYC, 32'h0, rdy);
        6:       step(1, A_ST, $urandom, rdy);
        default: begin
          if ($urandom_range(0, 3) == 0) step(1, A_CYC, $urandom, rdy);
          else step(0, 32'hFFFF_000C, 32'h0, rdy);
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_dmem.md
Name: mips_dmem

Overview:
- Memory-side responder for the single-cycle MIPS core's data port.
- Consumes the core's memwrite, aluout (address) and writedata; returns readdata in the same cycle.
- Backs a word-addressed data RAM plus a small memory-mapped I/O window: a free-running cycle counter and an output FIFO drained by an external consumer over a valid/ready handshake.
- Sits beside the core in the top-level, opposite the core's data-port outputs.

Parameters:
- ADDR_BITS, 8, RAM word-address width; RAM depth = 2^ADDR_BITS words.
- MMIO_BASE, 32'hFFFF_0000, base byte address of the MMIO window. Any address with aluout[31:16] == MMIO_BASE[31:16] is MMIO.
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- memwrite  in  1  store strobe from core.
- aluout  in  32  byte address from core.
- writedata  in  32  store data from core.
- readdata  out  32  load data to core, combinational.
- out_valid  out  1  FIFO head valid.
- out_data  out  32  FIFO head word.
- out_ready  in  1  consumer accepts head.

Behaviour:
- Reset (reset=0, async): cycle counter=0, FIFO empty, overflow=0, out_valid=0, out_data=0, readdata=0. RAM contents are not cleared.
- RAM reads: asynchronous, index aluout[ADDR_BITS+1:2]. Non-MMIO addresses above RAM size alias (wrap). aluout[1:0] is ignored for indexing.
- RAM writes: on the rising edge when memwrite=1 and the address is not MMIO. A same-cycle read of the written word returns the old value.
- MMIO offsets (aluout[15:0]):
  - 0x0 CYCLE: read returns counter. Write loads writedata; the counter shows writedata the next cycle, then increments.
  - 0x4 TXDATA: write pushes writedata into the FIFO. Read returns 0.
  - 0x8 STATUS: read returns {16'b0, count[7:0], 4'b0, misalign, overflow, full, empty}. A write with writedata[2]=1 clears overflow (W1C); all other bits are read-only.
  - Other offsets: read 0, writes ignored.
- Cycle counter: 32-bit, +1 every cycle, wraps 0xFFFF_FFFF→0. A load takes priority over the increment.
- FIFO:
  - Pop occurs when out_valid && out_ready on an edge. out_data = head; out_data and out_valid are registered outputs.
  - Push when full without a same-cycle pop: data dropped, overflow set (sticky).
  - Full with simultaneous push and pop: both occur, count unchanged, no overflow.
  - Empty with push: out_valid rises next cycle; a same-cycle pop is impossible.
  - count ranges 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation: FIFO contents discarded, out_valid drops immediately (async).

Optional Feature:
- Macro: MIPS_DMEM_ALIGN_CHECK_EN.
- Defined: any access (memwrite=1, or any cycle's address used for a read) with aluout[1:0]≠0 sets a sticky misalign bit (STATUS[3]), cleared by writing STATUS with writedata[3]=1. Misaligned stores are still performed, word-truncated.
- Undefined: no misalign logic; STATUS[3] reads 0.

Decomposition:
- Package mips_dmem_pkg:
  - MMIO offset constants: OFF_CYCLE, OFF_TXDATA, OFF_STATUS.
  - STATUS bit indices: ST_EMPTY, ST_FULL, ST_OVF, ST_MISALIGN.
  - Field position of count.
- One sub-module, mips_dmem_fifo: synchronous FIFO with push/pop, full/empty/count, registered head output.
- RAM, decode and counter stay in mips_dmem.

Test Plan:
- Store 0xDEADBEEF to 0x0000_0010, then load 0x10 → readdata=0xDEADBEEF. Load 0x0000_0410 (ADDR_BITS=8, aliases) → 0xDEADBEEF.
- Release reset, idle 10 cycles, read CYCLE → 10 (±1 per bench sampling convention, fixed in bench). Write CYCLE=0xFFFF_FFFE, read over 3 cycles → 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0.
- out_ready=0, push 1,2,3,4,5 to TXDATA → STATUS=0x0000_0406 (count 4, full, overflow). Then out_ready=1 → out_data 1,2,3,4 on consecutive accepts, then empty.
- FIFO full, same-cycle push 9 and pop → count stays 4, overflow not set. Write STATUS with bit2=1 → overflow clears.
- Push 0xA5, assert reset mid-stream → out_valid=0 immediately, STATUS=0x0000_0001 after release. RAM word written before reset is still readable.
- With MIPS_DMEM_ALIGN_CHECK_EN: store to 0x0000_0013 → STATUS[3]=1. Write STATUS with 0x8 → STATUS[3]=0. Without the macro → STATUS[3] stays 0.
